// File: rtl/id_ex_reg.sv
// ID/EX pipeline register between decode and execute.
// Carries the decoded operand bundle with a valid/ready handshake, a
// synchronous flush for branch-taken or exception kills, and a saturating
// back-pressure counter.
//
// Build option: define ID_EX_SKID_EN to add a skid register behind the main
// register so that in_ready comes straight from a flop instead of depending
// combinationally on out_ready. Without the macro a single register stage is
// built.
//
// Payload layout (MSB first, 146 bits):
//   pc[31:0], data_a[31:0], data_b[31:0], imme[31:0], alusrc,
//   alu_control[3:0], unsigned_num, equal_branch, shamt[4:0], wreg[4:0],
//   regwrite (bit 0)

module id_ex_reg (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [145:0] in_payload,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [145:0] out_payload,
   input  logic         flush,
   output logic [15:0]  stall_cycles
);

   localparam int unsigned PayloadW = 146;
   localparam logic [15:0] StallMax = 16'hFFFF;

   // Main register: the instruction currently offered to the execute stage
   logic                main_valid_q, main_valid_d;
   logic [PayloadW-1:0] main_data_q, main_data_d;

   logic                out_fire;
   logic                in_fire;

   logic [15:0]         stall_q, stall_d;

   assign out_valid = main_valid_q;
   assign out_fire  = main_valid_q & out_ready;
   assign in_fire   = in_valid & in_ready;

   // regwrite is gated by valid so a bubble can never write the register
   // file; every other field keeps its last value while the stage is empty.
   assign out_payload = {main_data_q[PayloadW-1:1], main_data_q[0] & main_valid_q};

`ifdef ID_EX_SKID_EN

   // Skid register: catches the one instruction accepted while main is
   // full and not draining. Only ever valid while main is valid.
   logic                skid_valid_q, skid_valid_d;
   logic [PayloadW-1:0] skid_data_q, skid_data_d;
   logic                ready_q;

   // in_ready is registered: it is simply "skid empty".
   assign in_ready = ready_q;

   // Next-state for main and skid registers; flush kills both
   always_comb begin
      main_valid_d = main_valid_q;
      main_data_d  = main_data_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (out_fire || !main_valid_q) begin
         // Main is free this edge: refill from skid first to keep FIFO order.
         // in_fire cannot coincide with a full skid since in_ready is low then.
         if (skid_valid_q) begin
            main_valid_d = 1'b1;
            main_data_d  = skid_data_q;
            skid_valid_d = 1'b0;
         end else begin
            main_valid_d = in_fire;
            if (in_fire) begin
               main_data_d = in_payload;
            end
         end
      end else if (in_fire) begin
         skid_valid_d = 1'b1;
         skid_data_d  = in_payload;
      end
   end

   // Main, skid and ready flops; reset leaves the stage empty and ready
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_valid_q <= 1'b0;
         main_data_q  <= '0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
         ready_q      <= 1'b1;
      end else begin
         main_valid_q <= main_valid_d;
         main_data_q  <= main_data_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
         ready_q      <= ~skid_valid_d;
      end
   end

`else

   // Single stage: accept whenever the held instruction is absent or leaving
   assign in_ready = ~main_valid_q | out_ready;

   // Next-state for the main register; flush discards held and incoming data
   always_comb begin
      main_valid_d = main_valid_q;
      main_data_d  = main_data_q;
      if (flush) begin
         main_valid_d = 1'b0;
      end else if (in_fire) begin
         main_valid_d = 1'b1;
         main_data_d  = in_payload;
      end else if (out_fire) begin
         main_valid_d = 1'b0;
      end
   end

   // Main register flops
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_valid_q <= 1'b0;
         main_data_q  <= '0;
      end else begin
         main_valid_q <= main_valid_d;
         main_data_q  <= main_data_d;
      end
   end

`endif

   // Count cycles where execute holds off a valid instruction; a flush cycle
   // is a kill, not a stall, so it is excluded.
   always_comb begin
      stall_d = stall_q;
      if (main_valid_q && !out_ready && !flush && (stall_q != StallMax)) begin
         stall_d = stall_q + 16'd1;
      end
   end

   // Stall counter flop; cleared only by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign stall_cycles = stall_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed bench for id_ex_reg. Works for both the default and the
// ID_EX_SKID_EN build; only the in_ready expectations differ.

module tb_id_ex_reg;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [145:0] in_payload;
   logic         out_valid;
   logic         out_ready;
   logic [145:0] out_payload;
   logic         flush;
   logic [15:0]  stall_cycles;

   int   n_tests;
   int   n_fail;
   logic last_acc;
   int   idx;
   logic [31:0] bp_pc [3];
   logic skid_build;

   id_ex_reg dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_payload   (in_payload),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_payload  (out_payload),
      .flush        (flush),
      .stall_cycles (stall_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Build a distinctive payload from a pc value and the regwrite bit
   function automatic logic [145:0] mk(input logic [31:0] pc, input logic rw);
      return {pc, ~pc, pc ^ 32'h5a5a_5a5a, pc + 32'd7, pc[0], pc[5:2], pc[1], pc[2],
              pc[10:6], pc[7:3], rw};
   endfunction

   task automatic check(input string tag, input logic [145:0] obs, input logic [145:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Record the handshake just before the edge, then land 2 time units past it
   task automatic tick();
      @(negedge clk);
      last_acc = in_valid && in_ready;
      @(posedge clk);
      #2;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
`ifdef ID_EX_SKID_EN
      skid_build = 1'b1;
`else
      skid_build = 1'b0;
`endif
      bp_pc[0] = 32'h100;
      bp_pc[1] = 32'h104;
      bp_pc[2] = 32'h108;

      // ---------------- reset state ----------------
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      in_payload = '0;
      out_ready  = 1'b1;
      flush      = 1'b0;
      #1;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_payload", out_payload, '0);
      check("rst_stall", stall_cycles, 16'd0);
      check("rst_in_ready", in_ready, 1'b1);
      #6 rst_n = 1'b1;

      // ---------------- streaming ----------------
      for (int k = 0; k < 8; k++) begin
         in_valid   = 1'b1;
         in_payload = mk(32'h0040_0000 + 32'(4 * k), 1'b1);
         #1;
         check($sformatf("stream_in_ready_%0d", k), in_ready, 1'b1);
         tick();
         check($sformatf("stream_valid_%0d", k), out_valid, 1'b1);
         check($sformatf("stream_pc_%0d", k), out_payload[145:114],
               32'h0040_0000 + 32'(4 * k));
      end
      in_valid = 1'b0;
      tick();
      check("stream_end_valid", out_valid, 1'b0);
      check("stream_end_rw", out_payload[0], 1'b0);
      check("stream_hold_pc", out_payload[145:114], 32'h0040_001c);

      // ---------------- bubble safety ----------------
      in_valid   = 1'b0;
      in_payload = mk(32'h0dead_000, 1'b1);
      for (int k = 0; k < 3; k++) begin
         tick();
         check($sformatf("bubble_rw_%0d", k), out_payload[0], 1'b0);
         check($sformatf("bubble_valid_%0d", k), out_valid, 1'b0);
      end

      // ---------------- back-pressure ----------------
      // First edge loads 0x100; the following five edges are stalled.
      idx        = 0;
      out_ready  = 1'b0;
      in_valid   = 1'b1;
      in_payload = mk(bp_pc[0], 1'b1);
      for (int e = 1; e <= 6; e++) begin
         tick();
         if (last_acc) idx++;
         in_valid = (idx < 3);
         if (idx < 3) in_payload = mk(bp_pc[idx], 1'b1);
         #1;
         check($sformatf("bp_hold_%0d", e), out_payload, mk(32'h100, 1'b1));
         check($sformatf("bp_valid_%0d", e), out_valid, 1'b1);
         if (e == 1) check("bp_ready_after_first", in_ready, skid_build);
         if (e == 2) check("bp_ready_after_second", in_ready, 1'b0);
      end
      check("bp_stall5", stall_cycles, 16'd5);
      out_ready = 1'b1;
      #1;
      check("bp_ready_release", in_ready, !skid_build);
      tick();
      if (last_acc) idx++;
      in_valid = (idx < 3);
      if (idx < 3) in_payload = mk(bp_pc[idx], 1'b1);
      check("bp_out_104", out_payload, mk(32'h104, 1'b1));
      tick();
      if (last_acc) idx++;
      in_valid = (idx < 3);
      check("bp_out_108", out_payload, mk(32'h108, 1'b1));
      check("bp_all_accepted", idx, 3);
      tick();
      check("bp_drained", out_valid, 1'b0);
      check("bp_stall_kept", stall_cycles, 16'd5);

      // ---------------- flush ----------------
      out_ready  = 1'b0;
      in_valid   = 1'b1;
      in_payload = mk(32'h200, 1'b1);
      tick();
      check("fl_pc200", out_payload, mk(32'h200, 1'b1));
      flush      = 1'b1;
      in_payload = mk(32'h204, 1'b1);
      tick();
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #1;
      check("fl_valid", out_valid, 1'b0);
      check("fl_rw", out_payload[0], 1'b0);
      check("fl_in_ready", in_ready, 1'b1);
      check("fl_stall", stall_cycles, 16'd5);
      for (int k = 0; k < 3; k++) begin
         tick();
         check($sformatf("fl_never_%0d", k), out_valid, 1'b0);
      end

      // ---------------- async reset ----------------
      out_ready  = 1'b0;
      in_valid   = 1'b1;
      in_payload = mk(32'h300, 1'b1);
      tick();
      in_valid = 1'b0;
      tick();
      check("ar_pre_valid", out_valid, 1'b1);
      check("ar_pre_stall", stall_cycles, 16'd6);
      #2 rst_n = 1'b0;
      #1;
      check("ar_valid", out_valid, 1'b0);
      check("ar_stall", stall_cycles, 16'd0);
      check("ar_payload", out_payload, '0);
      tick();
      check("ar_held_valid", out_valid, 1'b0);
      #2 rst_n = 1'b1;
      in_valid   = 1'b1;
      in_payload = mk(32'h400, 1'b1);
      out_ready  = 1'b1;
      #1;
      check("ar_no_partial", out_valid, 1'b0);
      tick();
      check("ar_first_valid", out_valid, 1'b1);
      check("ar_first_pc", out_payload, mk(32'h400, 1'b1));
      in_valid = 1'b0;
      tick();

      // ---------------- saturation ----------------
      out_ready  = 1'b0;
      in_valid   = 1'b1;
      in_payload = mk(32'h500, 1'b1);
      tick();
      in_valid = 1'b0;
      repeat (65534) @(posedge clk);
      #1;
      check("sat_fffe", stall_cycles, 16'hFFFE);
      tick();
      check("sat_ffff", stall_cycles, 16'hFFFF);
      repeat (70000 - 65535) @(posedge clk);
      #1;
      check("sat_nowrap", stall_cycles, 16'hFFFF);
      check("sat_hold", out_payload, mk(32'h500, 1'b1));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 clk  input  1  rising-edge clock; all state updates on this edge.
REQ-002 rst_n  input  1  asynchronous reset, active-low.
REQ-003 in_valid  input  1  decode stage presents a valid instruction.
REQ-004 in_ready  output  1  stage can accept an instruction this cycle.
REQ-005 in_payload  input  146  {pc[31:0], data_a[31:0], data_b[31:0], imme[31:0], alusrc, alu_control[3:0], unsigned_num, equal_branch, shamt[4:0], wreg[4:0], regwrite}.
REQ-006 out_valid  output  1  execute-stage operands are valid.
REQ-007 out_ready  input  1  ALU/execute stage consumes the instruction this cycle.
REQ-008 out_payload  output  146  same field order as in_payload, registered.
REQ-009 flush  input  1  synchronous kill of all held instructions (branch taken / exception).
REQ-010 stall_cycles  output  16  saturating count of back-pressure cycles.

Function
REQ-011 Input transfer SHALL occur when in_valid && in_ready; output transfer SHALL occur when out_valid && out_ready.
REQ-012 Latency SHALL be 1 cycle: a payload accepted at edge N SHALL appear on out_payload with out_valid=1 after edge N.
REQ-013 out_payload SHALL remain bit-stable while out_valid && !out_ready.
REQ-014 The out_payload regwrite bit SHALL be the stored bit ANDed with out_valid, so bubbles never write the register file.
REQ-015 When out_valid=0, all other out_payload fields SHALL hold their last value; the fields are not zeroed.
REQ-016 No payload SHALL be dropped or duplicated. Ordering SHALL be strictly FIFO.
REQ-017 flush=1 SHALL clear every held valid bit at the next edge. An input accepted in the same cycle SHALL be discarded. out_valid=0 SHALL hold after that edge.
REQ-018 Flush SHALL take priority over simultaneous input and output transfers. The output transfer of that cycle SHALL still count as consumed by the downstream stage.
REQ-019 stall_cycles SHALL increment by 1 on every cycle with out_valid && !out_ready && !flush.
REQ-020 stall_cycles SHALL saturate at 16'hFFFF; it SHALL clear only on reset.

Reset
REQ-021 When rst_n=0, the block SHALL immediately clear: out_valid=0, all internal valid bits=0, out_payload=0, stall_cycles=0.
REQ-022 Reset asserted mid-transfer SHALL discard all held instructions. No partial payload SHALL appear after release.
REQ-023 The first transfer SHALL be possible at the first rising edge after rst_n deasserts.

Configuration
REQ-024 Macro ID_EX_SKID_EN SHALL select the buffering structure.
REQ-025 Without ID_EX_SKID_EN:
- single register stage;
- in_ready = !out_valid || out_ready, combinational;
- full throughput when out_ready=1.
REQ-026 With ID_EX_SKID_EN:
- main register plus one skid register;
- in_ready SHALL be a flop output, equal to "skid empty";
- an input accepted while main is full and not draining SHALL go to skid;
- on output transfer, skid contents SHALL move to main on the same edge;
- throughput, latency and ordering SHALL be identical to the non-skid build.
REQ-027 With ID_EX_SKID_EN, in_ready SHALL be 1 after reset. The flush of REQ-017 SHALL also clear the skid valid bit, with in_ready=1 on the following cycle.

Verification
REQ-028 Streaming: out_ready=1, 8 back-to-back inputs with pc=0x00400000+4k -> out_valid on cycles 1..8, pc in order, no gaps.
REQ-029 Back-pressure: out_ready=0 for 5 cycles while in_valid=1 with pc 0x100, 0x104, 0x108:
- both builds: out_payload stays at pc=0x100; stall_cycles=5;
- non-skid: in_ready=0 after the first accept;
- skid: in_ready=0 after the second accept, then 0x104 and 0x108 emerge in order.
REQ-030 Flush: hold pc=0x200 stalled, assert flush with in_valid=1 pc=0x204 -> next cycle out_valid=0, regwrite bit=0; neither 0x200 nor 0x204 is ever delivered.
REQ-031 Async reset: drop rst_n mid-cycle while out_valid=1 -> out_valid and stall_cycles read 0 before the next clock edge.
REQ-032 Saturation: hold out_valid=1, out_ready=0 for 70000 cycles -> stall_cycles=16'hFFFF, no wrap.
REQ-033 Bubble safety: in_valid=0 with the in_payload regwrite bit=1 for 3 cycles -> the out_payload regwrite bit=0 throughout.
